// File: rtl/text_periph_responder.sv
// Peripheral-bus target: 16-word register window plus a character FIFO drained over valid/ready.
// Latency: ready appears 1+WAIT_STATES cycles after the strobe rising edge; writes commit on that edge.
// Backpressure: i_char_ready low holds the FIFO head; pushes into a full FIFO are dropped and flag overflow.
module text_periph_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic [7:0]  o_char,
    output logic        o_char_valid,
    input  logic        i_char_ready,
    output logic        o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic          strobe_q;
    logic [1:0]    state;
    logic [WW-1:0] wcnt;
    logic [31:0]   rd_hold;
    logic [31:0]   rd_val;

    logic          enable, irq_en, overflow;
    logic [31:0]   scratch;
    logic          enable_d, irq_en_d, overflow_d;
    logic [31:0]   scratch_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          empty, full, full_d, empty_d;
    logic          flush, push_req, push_ok, pop;

    logic          decoded, access, wr_commit;
    logic [3:0]    off;

    assign off       = i_bus_addr[3:0];
    assign decoded   = (i_bus_addr[31:4] == BASE_ADDR[31:4]);
    assign access    = (state == S_IDLE) && i_bus_clk && !strobe_q && decoded;
    assign wr_commit = access && i_bus_we;

    assign empty        = (count == '0);
    assign full         = (count == CW'(FIFO_DEPTH));
    assign o_char_valid = enable && !empty;
    assign o_char       = empty ? 8'h00 : mem[rd_ptr];

    always_comb begin
        enable_d   = enable;
        irq_en_d   = irq_en;
        scratch_d  = scratch;
        overflow_d = overflow;
        flush      = 1'b0;
        push_req   = 1'b0;
        if (wr_commit) begin
            case (off)
                4'd0: begin
                    enable_d = i_bus_data[0];
                    flush    = i_bus_data[1];
                    irq_en_d = i_bus_data[2];
                end
                4'd1: if (i_bus_data[31]) overflow_d = 1'b0;
                4'd2: push_req = 1'b1;
                4'd3: scratch_d = i_bus_data;
                default: ;
            endcase
        end
        // A flush swallows any pop the consumer attempts in the same cycle.
        pop     = o_char_valid && i_char_ready && !flush;
        push_ok = push_req && (!full || pop);
        if (push_req && !push_ok) overflow_d = 1'b1;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_d = count + CW'(1);
                2'b01:   count_d = count - CW'(1);
                default: count_d = count;
            endcase
        end
        full_d  = (count_d == CW'(FIFO_DEPTH));
        empty_d = (count_d == '0);
    end

    // Read data reflects register state after this cycle's commits.
    always_comb begin
        rd_val = '0;
        if (!i_bus_we) begin
            case (off)
                4'd0:    rd_val = {29'd0, irq_en_d, 1'b0, enable_d};
                4'd1:    rd_val = {overflow_d, 13'd0, full_d, empty_d, 16'(count_d)};
                4'd3:    rd_val = scratch_d;
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge i_cpu_clk) begin
        if (push_ok) mem[wr_ptr] <= i_bus_data[7:0];
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            scratch  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_irq    <= 1'b0;
        end else begin
            enable   <= enable_d;
            irq_en   <= irq_en_d;
            overflow <= overflow_d;
            scratch  <= scratch_d;
            count    <= count_d;
            o_irq    <= irq_en_d && overflow_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            strobe_q         <= 1'b0;
            state            <= S_IDLE;
            wcnt             <= '0;
            rd_hold          <= '0;
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b0;
        end else begin
            strobe_q <= i_bus_clk;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        if (WAIT_STATES == 0) begin
                            state            <= S_ACK;
                            o_bus_data       <= rd_val;
                            o_bus_data_ready <= 1'b1;
                        end else begin
                            state   <= S_WAIT;
                            wcnt    <= WW'(WAIT_STATES);
                            rd_hold <= rd_val;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_bus_clk) begin
                        state <= S_IDLE;
                    end else if (wcnt == WW'(1)) begin
                        state            <= S_ACK;
                        o_bus_data       <= rd_hold;
                        o_bus_data_ready <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                S_ACK: begin
                    if (!i_bus_clk) begin
                        state            <= S_IDLE;
                        o_bus_data       <= '0;
                        o_bus_data_ready <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_periph_responder.sv
// Bench for text_periph_responder: two instances (0 and 3 wait states) against a queue-based model.
// Directed register/FIFO/reset scenarios followed by a randomized operation mix on the zero-wait instance.
module tb_text_periph_responder;

    localparam logic [31:0] BASE  = 32'h0000_F000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_stb [2];
    logic        bus_we  [2];
    logic [31:0] bus_addr[2];
    logic [31:0] bus_wdat[2];
    logic [31:0] bus_rdat[2];
    logic        bus_rdy [2];
    logic [7:0]  ch      [2];
    logic        ch_vld  [2];
    logic        ch_rdy  [2];
    logic        irq     [2];

    always #5 clk = ~clk;

    text_periph_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(bus_stb[0]), .i_bus_we(bus_we[0]),
        .i_bus_addr(bus_addr[0]), .i_bus_data(bus_wdat[0]), .o_bus_data(bus_rdat[0]),
        .o_bus_data_ready(bus_rdy[0]), .o_char(ch[0]), .o_char_valid(ch_vld[0]),
        .i_char_ready(ch_rdy[0]), .o_irq(irq[0]));

    text_periph_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
        .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(bus_stb[1]), .i_bus_we(bus_we[1]),
        .i_bus_addr(bus_addr[1]), .i_bus_data(bus_wdat[1]), .o_bus_data(bus_rdat[1]),
        .o_bus_data_ready(bus_rdy[1]), .o_char(ch[1]), .o_char_valid(ch_vld[1]),
        .i_char_ready(ch_rdy[1]), .o_irq(irq[1]));

    int n_total = 0;
    int n_bad   = 0;

    // Reference state of instance 0
    logic [7:0]  mq[$];
    bit          m_en, m_irqen, m_ovf;
    logic [31:0] m_scratch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        int n;
        n = mq.size();
        return {m_ovf, 13'd0, n == DEPTH, n == 0, 16'(n)};
    endfunction

    function automatic void m_push(input logic [7:0] b, input bit pop_same);
        if (pop_same && m_en && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_en = 0; m_irqen = 0; m_ovf = 0; m_scratch = '0;
    endfunction

    task automatic bus_acc(input int sel, input logic we, input logic [3:0] off,
                           input logic [31:0] wd, input bit pop_now, output logic [31:0] rd);
        int lat;
        bit got;
        int ws;
        ws  = (sel == 1) ? 3 : 0;
        lat = 0;
        got = 0;
        bus_we[sel]   = we;
        bus_addr[sel] = {BASE[31:4], off};
        bus_wdat[sel] = wd;
        bus_stb[sel]  = 1'b1;
        if (pop_now) ch_rdy[sel] = 1'b1;
        while (!got && lat < 40) begin
            tick();
            lat++;
            ch_rdy[sel] = 1'b0;
            if (bus_rdy[sel]) got = 1;
        end
        check("ack_latency", 32'(lat), 32'(1 + ws));
        rd = bus_rdat[sel];
        tick();
        check("ack_hold", 32'(bus_rdy[sel]), 32'd1);
        bus_stb[sel] = 1'b0;
        tick();
        check("rdy_drop", 32'(bus_rdy[sel]), 32'd0);
        check("dat_drop", bus_rdat[sel], 32'd0);
        tick();
    endtask

    task automatic bus_rd(input int sel, input logic [3:0] off, output logic [31:0] rd);
        bus_acc(sel, 1'b0, off, $urandom, 1'b0, rd);
    endtask

    task automatic bus_wr(input int sel, input logic [3:0] off, input logic [31:0] wd, input bit pop_now);
        logic [31:0] rd;
        bus_acc(sel, 1'b1, off, wd, pop_now, rd);
        check("wr_data_zero", rd, 32'd0);
    endtask

    task automatic drain(input int cycles);
        bit v;
        for (int i = 0; i < cycles; i++) begin
            v = m_en && mq.size() > 0;
            check("char_valid", 32'(ch_vld[0]), 32'(v));
            check("char_byte", 32'(ch[0]), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            ch_rdy[0] = 1'b1;
            tick();
            if (v) void'(mq.pop_front());
        end
        ch_rdy[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, d;
        logic [7:0]  b;
        bit          seen;
        int          op, b_count;

        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            bus_stb[s] = 0; bus_we[s] = 0; bus_addr[s] = '0; bus_wdat[s] = '0; ch_rdy[s] = 0;
        end
        m_reset();
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_ready", 32'(bus_rdy[0]), 32'd0);
        check("rst_data", bus_rdat[0], 32'd0);
        check("rst_valid", 32'(ch_vld[0]), 32'd0);
        check("rst_char", 32'(ch[0]), 32'd0);
        check("rst_irq", 32'(irq[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        bus_rd(0, 4'd1, rd);
        check("status_after_reset", rd, 32'h0001_0000);

        bus_wr(0, 4'd3, 32'hDEAD_BEEF, 0);
        m_scratch = 32'hDEAD_BEEF;
        bus_rd(0, 4'd3, rd);
        check("scratch_rb", rd, 32'hDEAD_BEEF);

        // Access outside the window must never be acknowledged
        bus_we[0] = 1'b0; bus_addr[0] = 32'h0000_E003; bus_stb[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_rdy[0]) seen = 1;
        end
        check("undecoded_no_ack", 32'(seen), 32'd0);
        bus_stb[0] = 1'b0;
        tick();

        bus_wr(0, 4'd0, 32'h1, 0);
        m_en = 1;
        bus_wr(0, 4'd2, 32'h41, 0); m_push(8'h41, 0);
        bus_wr(0, 4'd2, 32'h42, 0); m_push(8'h42, 0);
        bus_wr(0, 4'd2, 32'h43, 0); m_push(8'h43, 0);
        check("abc_char", 32'(ch[0]), 32'h41);
        check("abc_valid", 32'(ch_vld[0]), 32'd1);
        bus_rd(0, 4'd1, rd);
        check("abc_status", rd, 32'h0000_0003);
        drain(3);
        check("abc_empty_valid", 32'(ch_vld[0]), 32'd0);
        bus_rd(0, 4'd1, rd);
        check("abc_empty_status", rd, 32'h0001_0000);

        // Fill to full, push+pop while full, then overflow
        bus_wr(0, 4'd0, 32'h7, 0);
        mq.delete(); m_en = 1; m_irqen = 1;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            bus_wr(0, 4'd2, {24'($urandom), b}, 0);
            m_push(b, 0);
        end
        bus_rd(0, 4'd1, rd);
        check("full_status", rd, 32'h0002_0010);
        b = 8'($urandom);
        bus_wr(0, 4'd2, {24'd0, b}, 1);
        m_push(b, 1);
        bus_rd(0, 4'd1, rd);
        check("full_pushpop_status", rd, 32'h0002_0010);
        check("full_pushpop_irq", 32'(irq[0]), 32'd0);
        bus_wr(0, 4'd2, 32'h0000_00EE, 0);
        m_push(8'hEE, 0);
        bus_rd(0, 4'd1, rd);
        check("ovf_status", rd, 32'h8002_0010);
        check("ovf_irq", 32'(irq[0]), 32'd1);
        bus_wr(0, 4'd1, 32'h8000_0000, 0);
        m_ovf = 0;
        check("ovf_clr_irq", 32'(irq[0]), 32'd0);
        bus_rd(0, 4'd1, rd);
        check("ovf_clr_status", rd, 32'h0002_0010);
        drain(4);
        bus_rd(0, 4'd0, rd);
        check("ctrl_rb", rd, 32'h0000_0005);
        bus_wr(0, 4'd0, 32'h3, 0);
        mq.delete(); m_irqen = 0;
        bus_rd(0, 4'd1, rd);
        check("flush_status", rd, 32'h0001_0000);

        // Wait-state instance: latency, then an aborted TXDATA write
        bus_rd(1, 4'd1, rd);
        check("ws3_status", rd, 32'h0001_0000);
        bus_we[1] = 1'b1; bus_addr[1] = {BASE[31:4], 4'd2}; bus_wdat[1] = 32'h0000_005A; bus_stb[1] = 1'b1;
        seen = 0;
        tick(); if (bus_rdy[1]) seen = 1;
        tick(); if (bus_rdy[1]) seen = 1;
        bus_stb[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_rdy[1]) seen = 1;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        b_count = 1;
        bus_rd(1, 4'd1, rd);
        check("abort_count", rd, 32'(b_count));
        check("abort_char", 32'(ch[1]), 32'h5A);
        check("abort_valid_dis", 32'(ch_vld[1]), 32'd0);

        // Randomized operation mix on instance 0
        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 11);
            case (op)
                0: begin
                    d = $urandom;
                    bus_wr(0, 4'd3, d, 0);
                    m_scratch = d;
                end
                1: begin
                    bus_rd(0, 4'd3, rd);
                    check("rnd_scratch", rd, m_scratch);
                end
                2, 3, 4, 5: begin
                    d = $urandom;
                    bus_wr(0, 4'd2, d, 0);
                    m_push(d[7:0], 0);
                end
                6: begin
                    bus_rd(0, 4'd1, rd);
                    check("rnd_status", rd, m_status());
                end
                7: drain($urandom_range(1, 4));
                8: begin
                    d = $urandom;
                    d[1] = ($urandom_range(0, 3) == 0);
                    d[0] = ($urandom_range(0, 3) != 0);
                    bus_wr(0, 4'd0, d, 0);
                    m_en = d[0]; m_irqen = d[2];
                    if (d[1]) mq.delete();
                end
                9: begin
                    bus_rd(0, 4'd0, rd);
                    check("rnd_ctrl", rd, {29'd0, m_irqen, 1'b0, m_en});
                end
                10: begin
                    d = $urandom;
                    bus_wr(0, 4'd1, d, 0);
                    if (d[31]) m_ovf = 0;
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        bus_wr(0, 4'($urandom_range(4, 15)), $urandom, 0);
                    end else begin
                        bus_rd(0, ($urandom_range(0, 1) == 0) ? 4'd2 : 4'($urandom_range(4, 15)), rd);
                        check("rnd_zero_read", rd, 32'd0);
                    end
                end
            endcase
            check("rnd_irq", 32'(irq[0]), 32'(m_irqen && m_ovf));
        end
        bus_rd(0, 4'd1, rd);
        check("rnd_final_status", rd, m_status());

        // Reset asserted in the middle of an acknowledged access
        bus_wr(0, 4'd0, 32'h3, 0);
        mq.delete(); m_en = 1; m_irqen = 0;
        for (int i = 0; i < 5; i++) begin
            bus_wr(0, 4'd2, 32'(8'h30 + i), 0);
            m_push(8'(8'h30 + i), 0);
        end
        bus_rd(0, 4'd1, rd);
        check("pre_rst_status", rd, 32'h0000_0005);
        bus_we[0] = 1'b0; bus_addr[0] = {BASE[31:4], 4'd1}; bus_stb[0] = 1'b1;
        tick();
        check("pre_rst_ack", 32'(bus_rdy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus_rdy[0]), 32'd0);
        check("midrst_data", bus_rdat[0], 32'd0);
        check("midrst_valid", 32'(ch_vld[0]), 32'd0);
        check("midrst_char", 32'(ch[0]), 32'd0);
        bus_stb[0] = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_reset();
        tick();
        bus_rd(0, 4'd1, rd);
        check("post_rst_status", rd, 32'h0001_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
